// File: rtl/lsu_pkg.sv
// Shared operation/state encodings and decode helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_OP_LB  = 3'b000,
        LSU_OP_LH  = 3'b001,
        LSU_OP_LW  = 3'b010,
        LSU_OP_SB  = 3'b011,
        LSU_OP_LBU = 3'b100,
        LSU_OP_LHU = 3'b101,
        LSU_OP_SH  = 3'b110,
        LSU_OP_SW  = 3'b111
    } lsu_op_e;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_REQ  = 2'd1,
        LSU_ST_RESP = 2'd2,
        LSU_ST_EXC  = 2'd3
    } lsu_state_e;

    localparam int unsigned LSU_CNT_W = 16;

    function automatic logic op_is_store(input lsu_op_e op);
        return op inside {LSU_OP_SB, LSU_OP_SH, LSU_OP_SW};
    endfunction

    function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
        case (op)
            LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: return addr_lo[0];
            LSU_OP_LW, LSU_OP_SW:             return addr_lo != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and builds store
// byte enables plus lane-replicated store data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] ld_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        ld_data  = word;
        st_be    = 4'b1111;
        st_wdata = word;
        case (op)
            LSU_OP_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_OP_LBU: ld_data = {24'h0, byte_sel};
            LSU_OP_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            LSU_OP_LHU: ld_data = {16'h0, half_sel};
            LSU_OP_SB: begin
                st_be    = 4'b0001 << addr_lo;
                st_wdata = {4{word[7:0]}};
            end
            LSU_OP_SH: begin
                st_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{word[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one operation at a time, single-outstanding memory
// request with timeout, aligned load write-back and misalign/timeout pulses.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rdst,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rdst,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_timeout,
    output logic [31:0] exc_addr
);

    localparam logic [LSU_CNT_W-1:0] CNT_LAST = LSU_CNT_W'(MEM_TIMEOUT - 1);

    lsu_state_e           state_q, state_d;
    lsu_op_e              op_q, op_d;
    logic [31:0]          addr_q, addr_d;
    logic [4:0]           rdst_q, rdst_d;
    logic [LSU_CNT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 we_q, we_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          wb_data_q, wb_data_d;

    lsu_op_e     req_op_e;
    lsu_op_e     al_op;
    logic [1:0]  al_lo;
    logic [31:0] al_word;
    logic [31:0] al_ld;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;

    assign req_op_e = lsu_op_e'(req_op);

    // One aligner serves both paths: in IDLE it shapes the incoming store,
    // otherwise it extracts the lane of the latched load from the read word.
    assign al_op   = (state_q == LSU_ST_IDLE) ? req_op_e : op_q;
    assign al_lo   = (state_q == LSU_ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
    assign al_word = (state_q == LSU_ST_IDLE) ? req_wdata : dmem_rdata;

    lsu_lane_align u_align (
        .op       (al_op),
        .addr_lo  (al_lo),
        .word     (al_word),
        .ld_data  (al_ld),
        .st_be    (al_be),
        .st_wdata (al_wdata)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        rdst_d    = rdst_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        wb_data_d = wb_data_q;
        case (state_q)
            LSU_ST_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op_e;
                    addr_d    = req_addr;
                    rdst_d    = req_rdst;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    we_d      = op_is_store(req_op_e);
                    be_d      = al_be;
                    wdata_d   = al_wdata;
                    case (req_op_e)
                        LSU_OP_LB, LSU_OP_LH, LSU_OP_LW, LSU_OP_LBU, LSU_OP_LHU,
                        LSU_OP_SB, LSU_OP_SH, LSU_OP_SW:
                            state_d = op_misaligned(req_op_e, req_addr[1:0]) ? LSU_ST_EXC
                                                                              : LSU_ST_REQ;
                        default: state_d = LSU_ST_IDLE;
                    endcase
                end
            end
            LSU_ST_REQ: begin
                // An ack on the final counted cycle takes priority over the timeout.
                if (dmem_ack) begin
                    if (op_is_store(op_q)) begin
                        state_d = LSU_ST_IDLE;
                    end else begin
                        state_d   = LSU_ST_RESP;
                        wb_data_d = al_ld;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = LSU_ST_EXC;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LSU_ST_RESP: state_d = LSU_ST_IDLE;
            LSU_ST_EXC:  state_d = LSU_ST_IDLE;
            default:     state_d = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= LSU_ST_IDLE;
            op_q      <= LSU_OP_LB;
            addr_q    <= '0;
            rdst_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rdst_q    <= rdst_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign req_ready    = (state_q == LSU_ST_IDLE);
    assign dmem_req     = (state_q == LSU_ST_REQ);
    assign dmem_we      = we_q;
    assign dmem_be      = be_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign wb_valid     = (state_q == LSU_ST_RESP);
    assign wb_rdst      = rdst_q;
    assign wb_data      = wb_data_q;
    assign exc_misalign = (state_q == LSU_ST_EXC) && !timeout_q;
    assign exc_timeout  = (state_q == LSU_ST_EXC) && timeout_q;
    assign exc_addr     = addr_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: reset checks, a directed vector table, multi-cycle corner
// sequences, and randomized operations against a transaction-level model.
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rdst;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rdst;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        exc_timeout;
    logic [31:0] exc_addr;

    lsu #(.MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rdst     (req_rdst),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_be      (dmem_be),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_rdst      (wb_rdst),
        .wb_data      (wb_data),
        .exc_misalign (exc_misalign),
        .exc_timeout  (exc_timeout),
        .exc_addr     (exc_addr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req;
        logic        wb;
        logic [31:0] data;
        logic        mis;
        logic        to;
        int          occ;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          k;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic we, input logic [3:0] be, input logic [31:0] wd,
                                input int req, input logic wb, input logic [31:0] data,
                                input logic mis, input logic to, input int occ);
        exp_t e;
        e.we = we; e.be = be; e.wdata = wd; e.req = req; e.wb = wb;
        e.data = data; e.mis = mis; e.to = to; e.occ = occ;
        return e;
    endfunction

    // Transaction-level reference: access size, lane arithmetic and latency from the rules.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd, input int k);
        exp_t e;
        int size, a;
        bit store, sgn, acked;
        logic [31:0] mask, v;
        e = '0;
        a = int'(addr % 4);
        store = (op == 3'd3 || op == 3'd6 || op == 3'd7);
        sgn = (op == 3'd0 || op == 3'd1);
        case (op)
            3'd0, 3'd3, 3'd4: size = 1;
            3'd1, 3'd5, 3'd6: size = 2;
            default:          size = 4;
        endcase
        if (a % size != 0) begin
            e.mis = 1'b1;
            e.occ = 2;
            return e;
        end
        acked = (k >= 1 && k <= TO);
        e.req = acked ? k : TO;
        e.to  = !acked;
        e.we  = store;
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        if (store) begin
            e.be = 4'(((1 << size) - 1) << a);
            if (size == 1)      e.wdata = (wd & 32'hFF) * 32'h0101_0101;
            else if (size == 2) e.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
            else                e.wdata = wd;
            e.occ = acked ? k + 1 : TO + 2;
        end else begin
            e.be = 4'hF;
            v = (rd >> (8 * a)) & mask;
            if (sgn && size < 4 && v >= (mask + 32'd1) / 2) v = v | ~mask;
            e.wb   = acked;
            e.data = acked ? v : 32'h0;
            e.occ  = acked ? k + 2 : TO + 2;
        end
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int k,
                           input logic [4:0] rdst, input exp_t e);
        int n, reqc, wbc, misc, toc, multi, occ;
        logic [31:0] a_got, w_got, wbd, ea;
        logic [3:0]  be_got;
        logic [4:0]  rd_got;
        logic        we_got, stable;
        reqc = 0; wbc = 0; misc = 0; toc = 0; multi = 0; occ = 0; stable = 1'b1;
        a_got = '0; w_got = '0; wbd = '0; ea = '0; be_got = '0; rd_got = '0; we_got = 1'b0;
        chk({tag, ".ready_before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rdst = rdst;
        step();
        req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (n <= 40 && occ == 0) begin
            if (req_ready) begin
                occ = n;
            end else begin
                dmem_ack = 1'b0;
                dmem_rdata = ~rd;
                if (dmem_req) begin
                    reqc++;
                    if (reqc == 1) begin
                        a_got = dmem_addr; be_got = dmem_be; w_got = dmem_wdata; we_got = dmem_we;
                    end else if (a_got !== dmem_addr || be_got !== dmem_be ||
                                 w_got !== dmem_wdata || we_got !== dmem_we) begin
                        stable = 1'b0;
                    end
                    if (reqc == k) begin
                        dmem_ack = 1'b1;
                        dmem_rdata = rd;
                    end
                end
                if (wb_valid) begin wbc++; wbd = wb_data; rd_got = wb_rdst; end
                if (exc_misalign) begin misc++; ea = exc_addr; end
                if (exc_timeout) begin toc++; ea = exc_addr; end
                if (int'(wb_valid) + int'(exc_misalign) + int'(exc_timeout) > 1) multi++;
                step();
                dmem_ack = 1'b0;
                n++;
            end
        end
        chk({tag, ".occupancy"}, 32'(occ), 32'(e.occ));
        chk({tag, ".req_cycles"}, 32'(reqc), 32'(e.req));
        chk({tag, ".wb_count"}, 32'(wbc), {31'b0, e.wb});
        chk({tag, ".misalign_count"}, 32'(misc), {31'b0, e.mis});
        chk({tag, ".timeout_count"}, 32'(toc), {31'b0, e.to});
        chk({tag, ".exclusive"}, 32'(multi), 32'd0);
        chk({tag, ".stable"}, 32'(stable), 32'd1);
        if (reqc > 0) begin
            chk({tag, ".dmem_addr"}, a_got, addr & 32'hFFFF_FFFC);
            chk({tag, ".dmem_be"}, 32'(be_got), 32'(e.be));
            chk({tag, ".dmem_we"}, 32'(we_got), {31'b0, e.we});
            if (e.we) chk({tag, ".dmem_wdata"}, w_got, e.wdata);
        end
        if (wbc > 0) begin
            chk({tag, ".wb_data"}, wbd, e.data);
            chk({tag, ".wb_rdst"}, 32'(rd_got), 32'(rdst));
        end
        if (misc + toc > 0) chk({tag, ".exc_addr"}, ea, addr);
    endtask

    vec_t vec[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0]  = '{3'd0, 32'h1003, 32'h0, 32'h80FF_FF12, 1, mk(0, 4'hF, 0, 1, 1, 32'hFFFF_FF80, 0, 0, 3)};
        vec[1]  = '{3'd4, 32'h1003, 32'h0, 32'h80FF_FF12, 1, mk(0, 4'hF, 0, 1, 1, 32'h0000_0080, 0, 0, 3)};
        vec[2]  = '{3'd6, 32'h2002, 32'h0000_BEEF, 32'h0, 3, mk(1, 4'hC, 32'hBEEF_BEEF, 3, 0, 0, 0, 0, 4)};
        vec[3]  = '{3'd2, 32'h3001, 32'h0, 32'h0, 1, mk(0, 4'h0, 0, 0, 0, 0, 1, 0, 2)};
        vec[4]  = '{3'd2, 32'h5000, 32'h0, 32'h0, 0, mk(0, 4'hF, 0, 4, 0, 0, 0, 1, 6)};
        vec[5]  = '{3'd2, 32'h5000, 32'h0, 32'h1234_5678, 4, mk(0, 4'hF, 0, 4, 1, 32'h1234_5678, 0, 0, 6)};
        vec[6]  = '{3'd3, 32'h6001, 32'h0000_00A5, 32'h0, 1, mk(1, 4'h2, 32'hA5A5_A5A5, 1, 0, 0, 0, 0, 2)};
        vec[7]  = '{3'd1, 32'h7002, 32'h0, 32'h8001_1234, 2, mk(0, 4'hF, 0, 2, 1, 32'hFFFF_8001, 0, 0, 4)};
        vec[8]  = '{3'd7, 32'h8000, 32'hDEAD_BEEF, 32'h0, 2, mk(1, 4'hF, 32'hDEAD_BEEF, 2, 0, 0, 0, 0, 3)};
        vec[9]  = '{3'd6, 32'h9001, 32'h0, 32'h0, 1, mk(0, 4'h0, 0, 0, 0, 0, 1, 0, 2)};
        vec[10] = '{3'd5, 32'h4002, 32'h0, 32'h8001_0000, 1, mk(0, 4'hF, 0, 1, 1, 32'h0000_8001, 0, 0, 3)};
        vec[11] = '{3'd3, 32'h000B, 32'h1234_567F, 32'h0, 0, mk(1, 4'h8, 32'h7F7F_7F7F, 4, 0, 0, 0, 1, 6)};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rdst = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        step(); step();
        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.dmem_req", 32'(dmem_req), 32'd0);
        chk("rst.dmem_we", 32'(dmem_we), 32'd0);
        chk("rst.dmem_be", 32'(dmem_be), 32'd0);
        chk("rst.dmem_addr", dmem_addr, 32'd0);
        chk("rst.dmem_wdata", dmem_wdata, 32'd0);
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.exc", {30'b0, exc_misalign, exc_timeout}, 32'd0);
        chk("rst.exc_addr", exc_addr, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++)
            run_txn($sformatf("vec%0d", i), vec[i].op, vec[i].addr, vec[i].wd, vec[i].rd,
                    vec[i].k, 5'(i + 3), vec[i].e);

        // Reset in the second REQ cycle of an LH, followed by a late ack.
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h2000; req_rdst = 5'd7;
        step();
        req_valid = 1'b0;
        chk("rstmid.req1", 32'(dmem_req), 32'd1);
        step();
        chk("rstmid.req2", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid.async_drop", 32'(dmem_req), 32'd0);
        chk("rstmid.ready", 32'(req_ready), 32'd1);
        step();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstmid.no_wb", 32'(wb_valid), 32'd0);
            chk("rstmid.no_exc", {30'b0, exc_misalign, exc_timeout}, 32'd0);
            chk("rstmid.no_req", 32'(dmem_req), 32'd0);
            chk("rstmid.idle", 32'(req_ready), 32'd1);
        end
        dmem_ack = 1'b0;

        // Back-to-back SW then LHU with req_valid held high.
        req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h4000; req_wdata = 32'h1122_3344; req_rdst = 5'd1;
        step();
        chk("b2b.busy", 32'(req_ready), 32'd0);
        chk("b2b.sw_req", 32'(dmem_req), 32'd1);
        chk("b2b.sw_we", 32'(dmem_we), 32'd1);
        chk("b2b.sw_wdata", dmem_wdata, 32'h1122_3344);
        dmem_ack = 1'b1;
        req_op = 3'd5; req_addr = 32'h4002; req_rdst = 5'd9;
        step();
        dmem_ack = 1'b0;
        chk("b2b.ready_back", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b.lhu_req", 32'(dmem_req), 32'd1);
        chk("b2b.lhu_we", 32'(dmem_we), 32'd0);
        chk("b2b.lhu_addr", dmem_addr, 32'h4000);
        chk("b2b.lhu_be", 32'(dmem_be), 32'hF);
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
        step();
        dmem_ack = 1'b0;
        chk("b2b.wb_valid", 32'(wb_valid), 32'd1);
        chk("b2b.wb_data", wb_data, 32'h0000_8001);
        chk("b2b.wb_rdst", 32'(wb_rdst), 32'd9);
        step();
        chk("b2b.wb_once", 32'(wb_valid), 32'd0);
        chk("b2b.ready_end", 32'(req_ready), 32'd1);

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] addr, wd, rd;
            int          k;
            op = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom;
            rd = $urandom;
            k = $urandom_range(0, 5);
            run_txn($sformatf("rand%0d", i), op, addr, wd, rd, k, 5'($urandom), model(op, addr, wd, rd, k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
